// File: rtl/seg7_hex_scanner_if.sv
// Bus between the debug-word source and the 4-digit seven-segment scanner.
// load is a one-cycle strobe with no backpressure: value/dp_mask are valid only when load=1.
interface seg7_hex_scanner_if;
   logic [15:0] value;
   logic        load;
   logic        lz_en;
   logic [3:0]  dp_mask;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_done;

   modport master (
      output value, load, lz_en, dp_mask,
      input  seg, dp, an, frame_done
   );

   modport slave (
      input  value, load, lz_en, dp_mask,
      output seg, dp, an, frame_done
   );
endinterface

// File: rtl/seg7_hex_scanner.sv
// Time-multiplexed 4-digit hex seven-segment driver with frame-synchronous
// update, anti-ghosting blanking, leading-zero suppression and decimal points.
module seg7_hex_scanner #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 500
) (
   input logic               clk,
   input logic               reset,
   seg7_hex_scanner_if.slave bus
);

   localparam int PW = $clog2(REFRESH_DIV);

   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   shadow_q, shadow_d;
   logic [3:0]    sdp_q, sdp_d;
   logic          pending_q, pending_d;
   logic [15:0]   disp_q, disp_d;
   logic [3:0]    dpr_q, dpr_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic          fd_q, fd_d;

   logic          tick;
   logic          wrap;
   logic [3:0]    nib;
   logic          supp;
   logic [6:0]    hex_seg;

   assign tick = (presc_q == PW'(REFRESH_DIV - 1));
   assign wrap = tick && (idx_q == 2'd3);

   always_comb begin
      presc_d   = tick ? '0 : presc_q + PW'(1);
      idx_d     = tick ? idx_q + 2'd1 : idx_q;
      shadow_d  = shadow_q;
      sdp_d     = sdp_q;
      pending_d = pending_q;
      disp_d    = disp_q;
      dpr_d     = dpr_q;
      if (bus.load) begin
         shadow_d  = bus.value;
         sdp_d     = bus.dp_mask;
         pending_d = 1'b1;
      end
      // A load landing on the wrap cycle commits immediately rather than waiting a frame.
      if (wrap) begin
         if (bus.load) begin
            disp_d    = bus.value;
            dpr_d     = bus.dp_mask;
            pending_d = 1'b0;
         end else if (pending_q) begin
            disp_d    = shadow_q;
            dpr_d     = sdp_q;
            pending_d = 1'b0;
         end
      end
   end

   always_comb begin
      nib = disp_q[idx_q*4 +: 4];
      case (idx_q)
         2'd1:    supp = bus.lz_en && (disp_q[15:4] == 12'h000);
         2'd2:    supp = bus.lz_en && (disp_q[15:8] == 8'h00);
         2'd3:    supp = bus.lz_en && (disp_q[15:12] == 4'h0);
         default: supp = 1'b0;
      endcase
      case (nib)
         4'h0:    hex_seg = 7'h40;
         4'h1:    hex_seg = 7'h79;
         4'h2:    hex_seg = 7'h24;
         4'h3:    hex_seg = 7'h30;
         4'h4:    hex_seg = 7'h19;
         4'h5:    hex_seg = 7'h12;
         4'h6:    hex_seg = 7'h02;
         4'h7:    hex_seg = 7'h78;
         4'h8:    hex_seg = 7'h00;
         4'h9:    hex_seg = 7'h10;
         4'hA:    hex_seg = 7'h08;
         4'hB:    hex_seg = 7'h03;
         4'hC:    hex_seg = 7'h46;
         4'hD:    hex_seg = 7'h21;
         4'hE:    hex_seg = 7'h06;
         default: hex_seg = 7'h0E;
      endcase
   end

   // Outputs are registered from this cycle's scan position, so they lag by one clock.
   always_comb begin
      an_d  = (int'(presc_q) < BLANK_CYCLES) ? 4'hF : ~(4'b0001 << idx_q);
      seg_d = supp ? 7'h7F : hex_seg;
      dp_d  = ~dpr_q[idx_q];
      fd_d  = wrap;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q   <= '0;
         idx_q     <= 2'd0;
         shadow_q  <= 16'h0000;
         sdp_q     <= 4'h0;
         pending_q <= 1'b0;
         disp_q    <= 16'h0000;
         dpr_q     <= 4'h0;
         an_q      <= 4'hF;
         seg_q     <= 7'h7F;
         dp_q      <= 1'b1;
         fd_q      <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         idx_q     <= idx_d;
         shadow_q  <= shadow_d;
         sdp_q     <= sdp_d;
         pending_q <= pending_d;
         disp_q    <= disp_d;
         dpr_q     <= dpr_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
         fd_q      <= fd_d;
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_hex_scanner.sv
// Bench for seg7_hex_scanner with REFRESH_DIV=4, BLANK_CYCLES=1 (16-cycle frame).
module tb_seg7_hex_scanner;

   logic clk;
   logic reset;
   seg7_hex_scanner_if bus();

   seg7_hex_scanner #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [11:0] exp_q[$];

   typedef struct {
      logic [15:0] value;
      logic [3:0]  dp_mask;
      logic        lz_en;
      logic [27:0] segs;   // {d3, d2, d1, d0}
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_frame(input logic [27:0] segs, input logic [3:0] dpm);
      for (int k = 0; k < 4; k++) begin
         logic [3:0] a;
         a = ~(4'b0001 << k);
         exp_q.push_back({a, segs[k*7 +: 7], ~dpm[k]});
      end
   endtask

   // Samples the first active cycle of each digit slot and compares against the queue.
   task automatic scan_frame(input int first_wait);
      logic [11:0] e;
      for (int k = 0; k < 4; k++) begin
         repeat ((k == 0) ? first_wait : 4) @(negedge clk);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scan_d%0d: got %0h expected <queue empty>", k, {bus.an, bus.seg, bus.dp});
         end else begin
            e = exp_q.pop_front();
            check($sformatf("scan_d%0d {an,seg,dp}", k), {20'h0, bus.an, bus.seg, bus.dp}, {20'h0, e});
         end
      end
   endtask

   task automatic wait_frame(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.frame_done && n < 40);
      if (!bus.frame_done) begin
         n_cmp++;
         n_fail++;
         $display("FAIL wait_frame: got no frame_done expected pulse within 40 cycles");
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] m);
      bus.value   = v;
      bus.dp_mask = m;
      bus.load    = 1'b1;
      @(negedge clk);
      bus.load    = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      logic [3:0] a_exp;
      logic [6:0] s_exp;

      vecs[0] = '{16'h1A3F, 4'b0000, 1'b0, {7'h79, 7'h08, 7'h30, 7'h0E}};
      vecs[1] = '{16'h0005, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}};
      vecs[2] = '{16'h0005, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h12}};
      vecs[3] = '{16'h0000, 4'b0101, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
      vecs[4] = '{16'h00F0, 4'b1010, 1'b1, {7'h7F, 7'h7F, 7'h0E, 7'h40}};
      vecs[5] = '{16'h0800, 4'b0000, 1'b1, {7'h7F, 7'h00, 7'h40, 7'h40}};
      vecs[6] = '{16'hC0D6, 4'b1111, 1'b0, {7'h46, 7'h40, 7'h21, 7'h02}};
      vecs[7] = '{16'h7954, 4'b0000, 1'b1, {7'h78, 7'h10, 7'h12, 7'h19}};
      vecs[8] = '{16'h2BE6, 4'b0000, 1'b0, {7'h24, 7'h03, 7'h06, 7'h02}};

      reset       = 1'b1;
      bus.value   = 16'h0000;
      bus.load    = 1'b0;
      bus.lz_en   = 1'b1;
      bus.dp_mask = 4'h0;
      repeat (3) @(negedge clk);
      check("reset an", bus.an, 4'hF);
      check("reset seg", bus.seg, 7'h7F);
      check("reset dp", bus.dp, 1'b1);
      check("reset frame_done", bus.frame_done, 1'b0);

      // First frame after release: blank then three active cycles per digit.
      reset = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         a_exp = ((c % 4) == 1) ? 4'hF : ~(4'b0001 << ((c - 1) / 4));
         s_exp = (((c - 1) / 4) == 0) ? 7'h40 : 7'h7F;
         check($sformatf("scan c%0d an", c), bus.an, a_exp);
         check($sformatf("scan c%0d seg", c), bus.seg, s_exp);
         check($sformatf("scan c%0d frame_done", c), bus.frame_done, (c == 16) ? 1 : 0);
      end

      // Mid-frame load: old display must persist until the next wrap.
      bus.lz_en = 1'b0;
      do_load(16'h1A3F, 4'b0000);
      push_frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000);
      scan_frame(1);
      wait_frame(n);
      check("frame period", n, 2);
      push_frame(vecs[0].segs, vecs[0].dp_mask);
      scan_frame(2);

      for (int i = 0; i < 9; i++) begin
         wait_frame(n);
         bus.lz_en = vecs[i].lz_en;
         do_load(vecs[i].value, vecs[i].dp_mask);
         wait_frame(n);
         check($sformatf("vec%0d sync", i), n, 15);
         push_frame(vecs[i].segs, vecs[i].dp_mask);
         scan_frame(2);
      end

      // lz_en toggle takes effect in the same active slot.
      wait_frame(n);
      bus.lz_en = 1'b1;
      do_load(16'h0005, 4'b0000);
      wait_frame(n);
      repeat (2) @(negedge clk);
      check("lz d0 seg", bus.seg, 7'h12);
      repeat (4) @(negedge clk);
      check("lz d1 an", bus.an, 4'hD);
      check("lz d1 seg suppressed", bus.seg, 7'h7F);
      bus.lz_en = 1'b0;
      @(negedge clk);
      check("lz off d1 an", bus.an, 4'hD);
      check("lz off d1 seg", bus.seg, 7'h40);

      // Load on the wrap cycle commits at once; the following load waits a frame.
      wait_frame(n);
      repeat (15) @(negedge clk);
      check("pre-wrap an", bus.an, 4'h7);
      bus.value   = 16'hBEEF;
      bus.dp_mask = 4'b0000;
      bus.load    = 1'b1;
      @(negedge clk);
      check("wrap frame_done", bus.frame_done, 1'b1);
      bus.value   = 16'h1234;
      @(negedge clk);
      bus.load    = 1'b0;
      push_frame({7'h03, 7'h06, 7'h06, 7'h0E}, 4'b0000);
      scan_frame(1);
      wait_frame(n);
      push_frame({7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000);
      scan_frame(2);

      // Reset during digit 2 with a load pending.
      wait_frame(n);
      do_load(16'h9999, 4'b1111);
      repeat (9) @(negedge clk);
      check("pre-reset an", bus.an, 4'hB);
      reset = 1'b1;
      #1;
      check("async reset an", bus.an, 4'hF);
      check("async reset seg", bus.seg, 7'h7F);
      check("async reset dp", bus.dp, 1'b1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      push_frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000);
      scan_frame(2);
      wait_frame(n);
      check("post-reset frame sync", n, 2);
      push_frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000);
      scan_frame(2);

      check("queue drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
